// File: rtl/control_pipeline.sv
// Pipeline control carrier: moves the decoded control bundle ID->EX->MEM->WB,
// detects load-use hazards, inserts bubbles on stall/flush and counts both events.
module control_pipeline (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regDst,
  input  logic        aluSrc,
  input  logic        memToReg,
  input  logic        regWrite,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        branch,
  input  logic        jump,
  input  logic [1:0]  aluOp,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic [4:0]  idRd,
  input  logic        flush,
  output logic        exRegDst,
  output logic        exAluSrc,
  output logic [1:0]  exAluOp,
  output logic [4:0]  exRt,
  output logic [4:0]  exDestReg,
  output logic        memMemRead,
  output logic        memMemWrite,
  output logic        memBranch,
  output logic        wbRegWrite,
  output logic        wbMemToReg,
  output logic [4:0]  wbDestReg,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  localparam int unsigned RegW = 5;
  localparam int unsigned CntW = 16;

  typedef struct packed {
    logic            regDst;
    logic            aluSrc;
    logic            memToReg;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic            branch;
    logic [1:0]      aluOp;
    logic [RegW-1:0] rt;
    logic [RegW-1:0] rd;
  } idExT;

  typedef struct packed {
    logic            memToReg;
    logic            regWrite;
    logic            memRead;
    logic            memWrite;
    logic            branch;
    logic [RegW-1:0] destReg;
  } exMemT;

  typedef struct packed {
    logic            memToReg;
    logic            regWrite;
    logic [RegW-1:0] destReg;
  } memWbT;

  idExT  idEx;
  exMemT exMem;
  memWbT memWb;
  idExT  idExNext;
  logic  hazard;
  logic  stall;

  // Jump is resolved before ID/EX and has no downstream consumer.
  logic  unusedJump;
  assign unusedJump = jump;

  // Load-use hazard against the instruction currently in ID/EX.
  always_comb begin
    hazard = idEx.memRead && (idEx.rt != RegW'(0)) &&
             ((idEx.rt == idRs) || (idEx.rt == idRt));
    stall  = hazard && !flush;
  end

  assign pcWrite   = !stall;
  assign ifIdWrite = !stall;
  assign exDestReg = idEx.regDst ? idEx.rd : idEx.rt;

  always_comb begin
    idExNext = '0;
    if (!stall && !flush) begin
      idExNext.regDst   = regDst;
      idExNext.aluSrc   = aluSrc;
      idExNext.memToReg = memToReg;
      idExNext.regWrite = regWrite;
      idExNext.memRead  = memRead;
      idExNext.memWrite = memWrite;
      idExNext.branch   = branch;
      idExNext.aluOp    = aluOp;
      idExNext.rt       = idRt;
      idExNext.rd       = idRd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idEx  <= '0;
      exMem <= '0;
      memWb <= '0;
    end else begin
      idEx           <= idExNext;
      exMem.memToReg <= idEx.memToReg;
      exMem.regWrite <= idEx.regWrite;
      exMem.memRead  <= idEx.memRead;
      exMem.memWrite <= idEx.memWrite;
      exMem.branch   <= idEx.branch;
      exMem.destReg  <= exDestReg;
      memWb.memToReg <= exMem.memToReg;
      memWb.regWrite <= exMem.regWrite;
      memWb.destReg  <= exMem.destReg;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall && (stallCount != '1)) stallCount <= stallCount + CntW'(1);
      if (flush && (flushCount != '1)) flushCount <= flushCount + CntW'(1);
    end
  end

  assign exRegDst    = idEx.regDst;
  assign exAluSrc    = idEx.aluSrc;
  assign exAluOp     = idEx.aluOp;
  assign exRt        = idEx.rt;
  assign memMemRead  = exMem.memRead;
  assign memMemWrite = exMem.memWrite;
  assign memBranch   = exMem.branch;
  assign wbRegWrite  = memWb.regWrite;
  assign wbMemToReg  = memWb.memToReg;
  assign wbDestReg   = memWb.destReg;

endmodule

// File: doc/control_pipeline.md
CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch, jump  in  1 each  decoded control bundle for the instruction in ID
- aluOp  in  2  decoded ALU op class for the instruction in ID
- idRs, idRt, idRd  in  5 each  register fields of the instruction in ID
- flush  in  1  branch taken or jump resolved in EX; the instruction in ID is wrong-path
- exRegDst, exAluSrc  out  1 each  ID/EX stage controls
- exAluOp  out  2  ID/EX stage ALU op class
- exRt  out  5  ID/EX rt field
- exDestReg  out  5  exRegDst ? exRd : exRt, combinational from ID/EX
- memMemRead, memMemWrite, memBranch  out  1 each  EX/MEM stage controls
- wbRegWrite, wbMemToReg  out  1 each  MEM/WB stage controls
- wbDestReg  out  5  MEM/WB destination register
- pcWrite, ifIdWrite  out  1 each  deasserted (0) while stalling
- stallCount, flushCount  out  16 each  saturating event counters

Function
REQ-002 Each rising edge SHALL advance the bundle ID->ID/EX->EX/MEM->MEM/WB; EX/MEM captures the memory and WB fields plus exDestReg; MEM/WB captures the WB fields plus the EX/MEM destination.
REQ-003 Latency from ID inputs: ex* outputs 1 cycle, mem* outputs 2 cycles, wb* outputs 3 cycles.
REQ-004 Load-use hazard SHALL be asserted combinationally when all three hold: ID/EX memRead=1; exRt!=0; exRt==idRs or exRt==idRt.
REQ-005 On hazard with flush=0, the block SHALL:
- drive pcWrite=0 and ifIdWrite=0 in that cycle
- load an all-zero bubble into ID/EX at the next edge
- let EX/MEM and MEM/WB advance normally
REQ-006 On flush=1, the next edge SHALL load an all-zero bubble into ID/EX; pcWrite=1 and ifIdWrite=1 for that cycle.
REQ-007 When flush and hazard coincide, flush SHALL win: no stall, stallCount unchanged, flushCount increments.
REQ-008 A bubble SHALL have every control bit and every register field 0, so it can never write a register, read memory or write memory.
REQ-009 Outside stall, pcWrite and ifIdWrite SHALL be 1.
REQ-010 A stall SHALL last exactly one cycle per hazard. The bubble clears ID/EX memRead, so back-to-back stalls on the same instruction are impossible.
REQ-011 stallCount SHALL increment by 1 on each edge where a stall is applied. flushCount SHALL increment by 1 on each edge where flush=1. Both saturate at 16'hFFFF and do not wrap.
REQ-012 The jump input SHALL take no part in hazard logic and SHALL NOT be carried past ID/EX. The branch input SHALL be carried to memBranch only.
REQ-013 An invalid opcode arrives as an all-zero bundle from the decoder and SHALL propagate as a bubble with no special handling.

Reset
REQ-014 When rst_n=0, the block SHALL asynchronously clear all pipeline registers and both counters to 0, independent of clk.
REQ-015 During reset, pcWrite and ifIdWrite SHALL read 1, since no stall is possible with ID/EX cleared.
REQ-016 Release of rst_n SHALL take effect at the first rising clk edge after deassertion.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight bundles, including any pending stall; no partial bundle reaches the wb* outputs.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- R-type (regDst=1, regWrite=1, aluOp=10, idRd=5): exDestReg=5 after 1 edge; wbRegWrite=1 and wbDestReg=5 after 3 edges; pcWrite=1 throughout.
- LW (memRead=1, memToReg=1, aluSrc=1, idRt=8), next instruction with idRs=8: pcWrite=ifIdWrite=0 for one cycle, ID/EX all zero next edge, stallCount=1, memMemRead=1 two edges after LW.
- LW with idRt=0 followed by a consumer of idRs=0: no stall, stallCount=0.
- Same hazard as the second scenario but with flush=1 in the hazard cycle: pcWrite=1, ID/EX bubble, stallCount=0, flushCount=1.
- SW (memWrite=1, aluSrc=1) then BEQ (branch=1, aluOp=01): memMemWrite=1 and then memBranch=1 on consecutive cycles; wbRegWrite=0 for both.
- rst_n pulsed low for a sub-cycle interval while a LW is in EX/MEM: all outputs 0 (pcWrite=ifIdWrite=1) immediately, without a clk edge; counters 0; no wbRegWrite after release.
- 70000 consecutive flush cycles: flushCount holds at 16'hFFFF.
